// File: rtl/seq_addsub_pkg.sv
// Shared types for the multi-cycle adder/subtractor: FSM states and op encoding.
package seq_addsub_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;
endpackage

// File: rtl/cpa_chunk.sv
// Combinational CHUNK-bit ripple-carry adder; also exposes the carry into the MSB
// so the caller can derive signed overflow on the top chunk.
module cpa_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co,
    output logic             c_msb
);
    logic [CHUNK:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign co    = c[CHUNK];
    assign c_msb = c[CHUNK-1];
endmodule

// File: rtl/seq_addsub.sv
// Multi-cycle WIDTH-bit add/sub: one shared CHUNK-bit ripple stage, carry held
// in a register between chunks, start/done handshake.
module seq_addsub
    import seq_addsub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int N  = WIDTH / CHUNK;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    state_t           state, state_nx;
    logic [WIDTH-1:0] a_q, b_q;
    logic             op_q;
    logic             carry_q;
    logic [IW-1:0]    idx;
    logic [CHUNK-1:0] ch_a, ch_b, ch_s;
    logic             ch_co, ch_cm;
    logic             last;

    // Subtract is a + ~b with the inverted borrow as carry-in.
    assign ch_a = a_q[idx*CHUNK +: CHUNK];
    assign ch_b = b_q[idx*CHUNK +: CHUNK] ^ {CHUNK{op_q == OP_SUB}};
    assign last = (idx == IW'(N - 1));

    cpa_chunk #(.CHUNK(CHUNK)) u_cpa (
        .a     (ch_a),
        .b     (ch_b),
        .ci    (carry_q),
        .s     (ch_s),
        .co    (ch_co),
        .c_msb (ch_cm)
    );

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (last) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= OP_ADD;
            carry_q <= 1'b0;
            idx     <= '0;
            sum     <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (start) begin
                    a_q     <= a;
                    b_q     <= b;
                    op_q    <= op;
                    carry_q <= cin ^ (op == OP_SUB);
                    idx     <= '0;
                end
                RUN: begin
                    sum[idx*CHUNK +: CHUNK] <= ch_s;
                    carry_q <= ch_co;
                    if (last) begin
                        idx  <= '0;
                        cout <= ch_co;
                        ovf  <= ch_co ^ ch_cm;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
